// File: rtl/gpu_pkg.sv
// Shared types for the memory dispatch path.
// Provides the SYNC opcode, the queued entry layout and the dispatcher state
// encoding used by memory_dispatch_queue.
package gpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PREG_W   = 16;
  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_SYNC = 4'b1111;

  // One queued instruction with its operand registers, instr in the MSBs.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PREG_W-1:0]  reg_a;
    logic [PREG_W-1:0]  reg_b;
    logic [PREG_W-1:0]  reg_c;
  } dispatch_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    SETTLE    = 2'd2,
    SYNC_WAIT = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Plain synchronous FIFO with occupancy count.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   push_i/wdata_i write request and data (ignored when full)
//   pop_i          read request (ignored when empty)
//   head_c_o       entry at the head, combinational from storage
//   count_o        registered occupancy, 0..DEPTH
//   full_c_o, empty_c_o  flags decoded from the registered count
module dispatch_fifo #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_c_o,
  output logic                     empty_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_c_o  = (count_q == CW'(DEPTH));
  assign empty_c_o = (count_q == '0);
  assign head_c_o  = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_c_o;
  assign pop_ok  = pop_i && !empty_c_o;

  // Pointer/count next state; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    if (pop_ok)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    count_d = CW'(count_q + CW'(push_ok) - CW'(pop_ok));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/memory_dispatch_queue.sv
// Buffers memory-bound instructions from controller and dispatches them to
// memory one at a time while memory is idle. SYNC entries are consumed here
// and stall dispatch until memory has been idle for SYNC_HOLD straight cycles.
// Ports:
//   clk_in, rst_in                      clock, async active-low reset
//   instr_in, reg_*_in, instr_valid_in  push side from controller
//   ready_out                           queue not full
//   memory_idle_in                      idle flag from memory
//   instr_out, reg_*_out                last dispatched entry (held)
//   instr_valid_out                     one-cycle dispatch pulse
//   queue_count_out                     current occupancy
//   sync_busy_out                       high while waiting out a SYNC
module memory_dispatch_queue
  import gpu_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = INSTR_W,
  parameter int unsigned PRIVATE_REG_WIDTH = PREG_W,
  parameter int unsigned QUEUE_DEPTH       = 4,
  parameter int unsigned SYNC_HOLD         = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [INSTRUCTION_WIDTH-1:0]    instr_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]    reg_a_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]    reg_b_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]    reg_c_in,
  input  logic                            instr_valid_in,
  output logic                            ready_out,
  input  logic                            memory_idle_in,
  output logic [INSTRUCTION_WIDTH-1:0]    instr_out,
  output logic [PRIVATE_REG_WIDTH-1:0]    reg_a_out,
  output logic [PRIVATE_REG_WIDTH-1:0]    reg_b_out,
  output logic [PRIVATE_REG_WIDTH-1:0]    reg_c_out,
  output logic                            instr_valid_out,
  output logic [$clog2(QUEUE_DEPTH):0]    queue_count_out,
  output logic                            sync_busy_out
);

  localparam int unsigned EW = INSTRUCTION_WIDTH + 3 * PRIVATE_REG_WIDTH;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned HW = $clog2(SYNC_HOLD + 1);
  localparam int unsigned RW = PRIVATE_REG_WIDTH;

  logic [EW-1:0]       head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;
  logic                pop;
  logic [OPCODE_W-1:0] head_op;

  dispatch_state_t     state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [RW-1:0]       reg_a_q, reg_b_q, reg_c_q;

  dispatch_fifo #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_ni    (rst_in),
    .push_i    (instr_valid_in),
    .wdata_i   ({instr_in, reg_a_in, reg_b_in, reg_c_in}),
    .pop_i     (pop),
    .head_c_o  (head),
    .count_o   (fifo_count),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty)
  );

  // Opcode occupies the top nibble (bits [0:3] in controller's MSB-first view).
  assign head_op = head[EW-1 -: OPCODE_W];

  // Dispatcher next-state: SYNC is popped regardless of memory_idle_in.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_op == OP_SYNC) begin
            pop     = 1'b1;
            hold_d  = '0;
            state_d = SYNC_WAIT;
          end else if (memory_idle_in) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE:  state_d = SETTLE;
      // memory has not yet registered the instruction, so idle is stale here
      SETTLE: state_d = IDLE;
      SYNC_WAIT: begin
        hold_d = memory_idle_in ? HW'(hold_q + 1'b1) : '0;
        if (hold_d == HW'(SYNC_HOLD)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SYNC_WAIT);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      hold_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      instr_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      reg_c_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      // Data registers only change on a real dispatch and hold otherwise.
      if (valid_d) begin
        instr_q <= head[EW-1 -: INSTRUCTION_WIDTH];
        reg_a_q <= head[3*RW-1 -: RW];
        reg_b_q <= head[2*RW-1 -: RW];
        reg_c_q <= head[RW-1:0];
      end
    end
  end

  assign ready_out       = !fifo_full;
  assign queue_count_out = fifo_count;
  assign instr_valid_out = valid_q;
  assign sync_busy_out   = busy_q;
  assign instr_out       = instr_q;
  assign reg_a_out       = reg_a_q;
  assign reg_b_out       = reg_b_q;
  assign reg_c_out       = reg_c_q;

endmodule
